// File: rtl/inst_mem_loader_pkg.sv
// Shared constants for the boot-time instruction memory loader:
// state encoding, default geometry and byte-lane count.
package loader_pkg;
  localparam int N_DEF         = 32;
  localparam int MEM_WORDS_DEF = 64;
  localparam int ADDR_W_DEF    = 6;
  localparam int BYTE_LANES    = 4;

  localparam logic [2:0] S_COUNT = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface inst_mem_loader_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) ();
  // A byte transfers on a rising clk edge where byte_valid && byte_ready;
  // byte_data must be stable while byte_valid is high and unaccepted.
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [N-1:0]      imem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_mem_loader_byte_assembler.sv
// Collects little-endian bytes into a 32-bit word and keeps a running XOR
// of every byte taken since the last clear.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic        clr,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full,
  output logic [7:0]  csum
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] lane_q, lane_d;
  logic [7:0]  csum_q, csum_d;

  // Bytes enter at the top and shift down, so byte 0 ends up in bits 7:0.
  assign word      = {byte_data, lane_q[31:8]};
  assign word_full = take && (idx_q == 2'(BYTE_LANES - 1));
  assign csum      = csum_q;

  always_comb begin
    idx_d  = idx_q;
    lane_d = lane_q;
    csum_d = csum_q;
    if (clr) begin
      idx_d  = 2'd0;
      lane_d = 32'd0;
      csum_d = 8'd0;
    end else if (take) begin
      idx_d  = idx_q + 2'd1;
      lane_d = word;
      csum_d = csum_q ^ byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= 2'd0;
      lane_q <= 32'd0;
      csum_q <= 8'd0;
    end else begin
      idx_q  <= idx_d;
      lane_q <= lane_d;
      csum_q <= csum_d;
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// Loads a counted, checksummed byte image into instruction memory and holds
// the core in reset until the image has been written and verified.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  inst_mem_loader_if.slave    bus,
  output logic                cpu_rst,
  output logic                done,
  output logic                err,
  output logic [2:0]          state_dbg
);
  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [7:0]        wcnt_inc;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              fire, take, clr, word_full;
  logic [31:0]       word;
  logic [7:0]        csum;

  assign bus.byte_ready = !rst && (state_q inside {S_COUNT, S_DATA, S_CSUM});
  assign fire           = bus.byte_valid && bus.byte_ready;
  assign take           = fire && (state_q == S_DATA);
  assign clr            = (state_q == S_COUNT);
  assign wcnt_inc       = wcnt_q + 8'd1;

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .take      (take),
    .clr       (clr),
    .byte_data (bus.byte_data),
    .word      (word),
    .word_full (word_full),
    .csum      (csum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      S_COUNT: if (fire) begin
        cnt_d = bus.byte_data;
        if (bus.byte_data == 8'd0) begin
          state_d = S_CSUM;
        end else if (int'(bus.byte_data) > MEM_WORDS) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      // The write port is loaded on the edge accepting the 4th byte so the
      // strobe is visible for exactly the one S_WRITE cycle.
      S_DATA: if (word_full) begin
        state_d = S_WRITE;
        we_d    = 1'b1;
        addr_d  = wcnt_q[ADDR_W-1:0];
        wdata_d = N'(word);
      end
      S_WRITE: begin
        wcnt_d  = wcnt_inc;
        state_d = (wcnt_inc == cnt_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (fire) begin
        if (bus.byte_data == csum) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_COUNT;
      cnt_q     <= 8'd0;
      wcnt_q    <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign done           = done_q;
  assign err            = err_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed and randomized image loads checked against a stream-level model
// of the loader's expected writes and final status.
module tb_inst_mem_loader;
  localparam int N         = 32;
  localparam int ADDR_W    = 6;
  localparam int MEM_WORDS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_rst, done, err;
  logic [2:0] state_dbg;

  inst_mem_loader_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  inst_mem_loader #(.N(N), .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]          stream_q[$];
  logic [ADDR_W+N-1:0] exp_q[$];
  logic [ADDR_W+N-1:0] got_q[$];
  bit                  exp_done, exp_err;
  int                  n_consume;

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && bus.imem_we) got_q.push_back({bus.imem_addr, bus.imem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what a correct loader must write and report for stream_q.
  task automatic build_model();
    logic [7:0]   c;
    logic [7:0]   x;
    logic [N-1:0] w_word;
    exp_q.delete();
    x = 8'd0;
    c = stream_q[0];
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (int'(c) > MEM_WORDS) begin
      exp_err   = 1'b1;
      n_consume = 1;
      return;
    end
    for (int w = 0; w < int'(c); w++) begin
      for (int b = 0; b < 4; b++) begin
        w_word[8*b +: 8] = stream_q[1 + 4*w + b];
        x ^= stream_q[1 + 4*w + b];
      end
      exp_q.push_back({ADDR_W'(w), w_word});
    end
    n_consume = 2 + 4 * int'(c);
    if (stream_q[n_consume-1] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic make_stream(input int c, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'd0;
    stream_q.delete();
    stream_q.push_back(8'(c));
    for (int i = 0; i < 4 * c; i++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      stream_q.push_back(b);
    end
    if (!good) x ^= 8'($urandom_range(1, 255));
    stream_q.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    @(negedge clk);
    if (gaps) begin
      bus.byte_valid = 1'b0;
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(bus.byte_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready",   64'(bus.byte_ready), 64'(0));
    chk("rst_we",      64'(bus.imem_we),    64'(0));
    chk("rst_addr",    64'(bus.imem_addr),  64'(0));
    chk("rst_wdata",   64'(bus.imem_wdata), 64'(0));
    chk("rst_cpu_rst", 64'(cpu_rst),        64'(1));
    chk("rst_done",    64'(done),           64'(0));
    chk("rst_err",     64'(err),            64'(0));
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic run_and_check(input string tag, input bit gaps);
    build_model();
    for (int i = 0; i < n_consume; i++) send_byte(stream_q[i], gaps);
    chk({tag, "_done_edge"}, 64'(done), 64'(exp_done));
    chk({tag, "_err_edge"},  64'(err),  64'(exp_err));
    repeat (3) @(negedge clk);
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_done"},    64'(done),           64'(exp_done));
    chk({tag, "_err"},     64'(err),            64'(exp_err));
    chk({tag, "_cpu_rst"}, 64'(cpu_rst),        64'(!exp_done));
    chk({tag, "_ready"},   64'(bus.byte_ready), 64'(0));
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;

    // Nominal two-word image.
    do_reset();
    stream_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_and_check("nominal", 1'b0);
    chk("nominal_w0", 64'(exp_q[0]), 64'({6'd0, 32'h0000_0013}));
    chk("nominal_w1", 64'(exp_q[1]), 64'({6'd1, 32'h0010_0093}));

    // Same image with a wrong checksum.
    do_reset();
    stream_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    run_and_check("badcsum", 1'b0);

    // Count larger than the memory.
    do_reset();
    stream_q = '{8'h41};
    run_and_check("toolong", 1'b0);

    // Zero-length images, good and bad checksum.
    do_reset();
    stream_q = '{8'h00, 8'h00};
    run_and_check("zero_ok", 1'b0);
    do_reset();
    stream_q = '{8'h00, 8'h01};
    run_and_check("zero_bad", 1'b0);

    // Full-depth image under random backpressure.
    do_reset();
    make_stream(MEM_WORDS, 1'b1);
    run_and_check("full", 1'b1);

    // Small random images, random checksum validity.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      make_stream($urandom_range(1, 8), 1'($urandom_range(0, 1)));
      run_and_check($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset after six data bytes of a three-word image.
    do_reset();
    make_stream(3, 1'b1);
    build_model();
    for (int i = 0; i < 7; i++) send_byte(stream_q[i], 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready",   64'(bus.byte_ready), 64'(0));
    chk("midrst_cpu_rst", 64'(cpu_rst),        64'(1));
    chk("midrst_we",      64'(bus.imem_we),    64'(0));
    chk("midrst_nwrites", 64'(got_q.size()),   64'(1));
    if (got_q.size() > 0) chk("midrst_wr0", 64'(got_q[0]), 64'(exp_q[0]));
    do_reset();
    stream_q = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run_and_check("after_rst", 1'b0);
    chk("after_rst_w0", 64'(exp_q[0]), 64'({6'd0, 32'hDEAD_BEEF}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time stage directly upstream of the single-cycle core's instruction memory.
- Receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory and verifies an XOR checksum.
- Holds the core in reset (cpu_rst) until the image is fully and correctly loaded, then releases it so the core fetches from PC 0.

Parameters:
- N, 32, instruction word width (bits).
- MEM_WORDS, 64, instruction memory depth in words (8-bit byte PC >> 2).
- ADDR_W, 6, word address width; must equal clog2(MEM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  N  assembled instruction word.
- cpu_rst  out  1  active-high reset to the core.
- done  out  1  image loaded and verified; sticky.
- err  out  1  load failed (length or checksum); sticky.

Behaviour:
- Reset and clocking: one clock (clk); reset rst is asynchronous, active-high. While rst is high: state=S_COUNT, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, checksum=0, byte index=0, word counter=0.
- Stream format: byte 0 = word count C (unsigned 8-bit), then C×4 data bytes (little-endian, word 0 first), then 1 checksum byte equal to the XOR of all data bytes. The count byte is not included in the checksum.
- byte_ready is 1 only in S_COUNT, S_DATA and S_CSUM, and only while rst is low. It is combinational from state.
- S_COUNT: on transfer, latch C.
  - C==0 goes to S_CSUM; an expected checksum of 0x00 applies.
  - C>MEM_WORDS goes to S_ERR.
  - Otherwise goes to S_DATA.
- S_DATA: each transfer shifts a byte into lane[idx] (idx 0..3) and XORs it into the checksum. When the 4th byte is accepted, go to S_WRITE.
- S_WRITE: lasts one cycle, with byte_ready=0. imem_we=1, imem_addr=word counter, imem_wdata=assembled word; all three are registered. The word counter then increments. If counter+1==C, go to S_CSUM; else go to S_DATA.
  - Latency: 4th byte accepted at edge t gives imem_we high during cycle t+1.
- S_CSUM: on transfer, a byte equal to the checksum goes to S_DONE; any other value goes to S_ERR.
- S_DONE: cpu_rst=0, done=1, byte_ready=0; further bytes are ignored. cpu_rst deasserts on the edge that enters S_DONE. Only rst exits.
- S_ERR: cpu_rst=1, err=1, byte_ready=0; only rst exits.
- Backpressure: byte_valid low stalls with no state change. There is no timeout.
- Reset mid-load: returns to S_COUNT and discards any partial word. Words already written stay in memory (they are not erased). The core remains in reset.
- C==MEM_WORDS is legal: the last write goes to address MEM_WORDS-1, and the counter does not wrap into address 0.
- imem_we never asserts outside S_WRITE. Exactly C write strobes occur per successful load.

Decomposition:
- Package loader_pkg:
  - State encoding localparams S_COUNT, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR.
  - Defaults for MEM_WORDS and ADDR_W.
  - Byte lane constant 4.
- Sub-module byte_assembler: 2-bit lane index, 32-bit shift/lane register and running XOR.
  - Inputs: clk, rst, take, clr, byte_data.
  - Outputs: word, word_full, csum.
- The top level holds the FSM, word counter and output registers.

Test Plan:
- Nominal load: stream 02, 13 00 00 00, 93 00 10 00, checksum 0x13^0x93^0x10=0x90. Expect:
  - imem_we pulses at addr 0 with 0x00000013, then at addr 1 with 0x00100093.
  - done=1, cpu_rst=0 one cycle after the checksum transfer.
  - err=0.
- Bad checksum: same stream with checksum 0x91. Expect both writes to occur, then err=1, cpu_rst stays 1, byte_ready=0, done=0.
- Length error: count byte 0x41 (65 > 64). Expect err=1 after one transfer, no imem_we, byte_ready=0.
- Zero-length image: stream 00, 00. Expect done=1, cpu_rst=0, no imem_we. A stream of 00, 01 gives err=1.
- Backpressure and boundary: C=64 with byte_valid toggled randomly.
  - Expect exactly 64 strobes at addresses 0..63 in order, each data word correct.
  - No strobe at address 0 after address 63; done=1.
- Reset mid-load: assert rst asynchronously after 6 data bytes.
  - Expect immediate byte_ready=0, cpu_rst=1, imem_we=0.
  - After release, a fresh 01, EF BE AD DE, checksum 0x22 writes 0xDEADBEEF at addr 0 and sets done=1.
